// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad front end: FSM encoding,
// column drive pattern and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'b00,
    DEBOUNCE = 2'b01,
    HELD     = 2'b10
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Rows top to bottom, columns left to right; '*' maps to E, '#' to F.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] cols);
    return {cols[2:0], cols[3]};
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to the
// idle (all pulled-up) pattern so no phantom press is seen out of reset.
module sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner/debouncer producing one user_latch strobe
// per accepted press. Define KEYPAD_REPEAT_EN to add hold-to-repeat strobes.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] user_digit,
  output logic       user_latch,
  output logic       key_held
);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_entry: illegal parameter value");
  end

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rs;
  logic [DW-1:0] div_cnt;
  logic          tick;

  state_t        state, state_nxt;
  logic [3:0]    col_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [CW-1:0] rel_cnt, rel_nxt;
  logic [3:0]    digit_nxt;
  logic          latch_nxt;
  logic          held_nxt;

  logic          single_low;
  logic          rows_idle;
  logic          key_match;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt, rep_nxt;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (rs)
  );

  // Explicit wrap keeps the dwell exact for non-power-of-two dividers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick       = (div_cnt == DIV_LAST);
  assign single_low = ($countones(~rs) == 1);
  assign rows_idle  = (rs == ROWS_IDLE);
  assign key_match  = (rs == ~(4'b0001 << row_idx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SCAN;
      col_out    <= COL_RESET;
      row_idx    <= '0;
      col_idx    <= '0;
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      user_digit <= '0;
      user_latch <= 1'b0;
      key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      col_out    <= col_nxt;
      row_idx    <= row_nxt;
      col_idx    <= col_idx_nxt;
      deb_cnt    <= deb_nxt;
      rel_cnt    <= rel_nxt;
      user_digit <= digit_nxt;
      user_latch <= latch_nxt;
      key_held   <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= rep_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col_out;
    row_nxt     = row_idx;
    col_idx_nxt = col_idx;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    digit_nxt   = user_digit;
    latch_nxt   = 1'b0;
    held_nxt    = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt     = rep_cnt;
`endif

    if (tick) begin
      case (state)
        SCAN: begin
          // Multiple low rows on one column is ghosting; treat as no press.
          if (single_low) begin
            row_nxt     = low_index(rs);
            col_idx_nxt = low_index(col_out);
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = rotate_col(col_out);
          end
        end

        DEBOUNCE: begin
          if (key_match) begin
            if (deb_cnt == DEB_LAST) begin
              state_nxt = HELD;
              deb_nxt   = '0;
              rel_nxt   = '0;
              latch_nxt = 1'b1;
              digit_nxt = key_code(row_idx, col_idx);
              held_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_nxt   = '0;
`endif
            end else begin
              deb_nxt = deb_cnt + 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            deb_nxt   = '0;
            col_nxt   = rotate_col(col_out);
          end
        end

        HELD: begin
          if (rows_idle) begin
`ifdef KEYPAD_REPEAT_EN
            rep_nxt = '0;
`endif
            if (rel_cnt == DEB_LAST) begin
              state_nxt = SCAN;
              rel_nxt   = '0;
              held_nxt  = 1'b0;
              col_nxt   = rotate_col(col_out);
            end else begin
              rel_nxt = rel_cnt + 1'b1;
            end
          end else begin
            rel_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
            // A bounce back to low mid-release restarts the repeat interval.
            if (rel_cnt != '0) begin
              rep_nxt = '0;
            end else if (key_match) begin
              if (rep_cnt == REP_LAST) begin
                latch_nxt = 1'b1;
                rep_nxt   = '0;
              end else begin
                rep_nxt = rep_cnt + 1'b1;
              end
            end
`endif
          end
        end

        default: begin
          state_nxt = SCAN;
          col_nxt   = COL_RESET;
          held_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
